// File: rtl/spi_request_arbiter_pkg.sv
// Shared types and register bit positions for the SPI request arbiter
// and the spi_controller register map it drives.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CTRL,
    WR_DATA,
    WAIT_IRQ,
    READ_STAT,
    DONE
  } state_e;

  localparam int IRQ_EN = 7;
  localparam int SPIE   = 6;
  localparam int DWORD  = 5;
  localparam int CPOL   = 3;
  localparam int CPHA   = 2;
  localparam int SPR1   = 1;
  localparam int SPR0   = 0;

  localparam int STAT_IRQ  = 7;
  localparam int STAT_COLL = 6;

  // Controller registers are 32 bits wide but only the low byte is meaningful.
  function automatic logic [31:0] reg_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/spi_request_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
// master = the arbiter, slave = requesters plus spi_controller.
interface spi_request_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ*8-1:0] i_req_ctrl;
  logic [NUM_REQ*8-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_done;
  logic [7:0]           o_rx_data;
  logic                 o_err_collision;
  logic                 o_err_timeout;
  logic [31:0]          o_data_to_registers;
  logic                 o_wr_controll_reg;
  logic                 o_wr_data_reg;
  logic                 o_read_status_reg;
  logic [31:0]          i_status_reg;
  logic [7:0]           i_rx_data;
  logic                 i_irq;

  modport master (
    input  i_req, i_req_ctrl, i_req_data, i_status_reg, i_rx_data, i_irq,
    output o_grant, o_done, o_rx_data, o_err_collision, o_err_timeout,
           o_data_to_registers, o_wr_controll_reg, o_wr_data_reg, o_read_status_reg
  );

  modport slave (
    output i_req, i_req_ctrl, i_req_data, i_status_reg, i_rx_data, i_irq,
    input  o_grant, o_done, o_rx_data, o_err_collision, o_err_timeout,
           o_data_to_registers, o_wr_controll_reg, o_wr_data_reg, o_read_status_reg
  );

endinterface

// File: rtl/spi_request_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after
// last_i+1 (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDXW-1:0]    idx_o,
  output logic               valid_o
);

  logic [IDXW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(last_i) + k + 1) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) begin
      gnt_o = NUM_REQ'(1) << idx_o;
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// Shares one spi_controller among NUM_REQ requesters: grant, write ctrl then
// data, wait for IRQ (or timeout), read status, and hand the result back.
module spi_request_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  RST_N,
  spi_request_arbiter_if.master bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic [IDXW-1:0]    last_q;
  logic [IDXW-1:0]    idx_q;
  logic [IDXW-1:0]    arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_valid;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CNTW-1:0]    cnt_q;
  logic [CNTW-1:0]    cnt_d;
  logic [7:0]         data_q;
  logic [7:0]         rx_q;
  logic [31:0]        dtr_q;
  logic               wr_ctrl_q;
  logic               wr_data_q;
  logic               rd_stat_q;
  logic               timeout_q;
  logic               err_coll_q;
  logic               err_tmo_q;
  logic               unused_status;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_rr (
    .req_i   (bus.i_req),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign cnt_d = cnt_q + CNTW'(1);

  // Strobes are set on the edge that enters their state, so each lasts exactly one cycle.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= IDXW'(NUM_REQ - 1);
      idx_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      rx_q       <= '0;
      dtr_q      <= '0;
      wr_ctrl_q  <= 1'b0;
      wr_data_q  <= 1'b0;
      rd_stat_q  <= 1'b0;
      timeout_q  <= 1'b0;
      err_coll_q <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      wr_ctrl_q <= 1'b0;
      wr_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
      done_q    <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q   <= arb_gnt;
            idx_q     <= arb_idx;
            dtr_q     <= reg_word(bus.i_req_ctrl[{arb_idx, 3'b000} +: 8]);
            data_q    <= bus.i_req_data[{arb_idx, 3'b000} +: 8];
            wr_ctrl_q <= 1'b1;
            state_q   <= WR_CTRL;
          end
        end
        WR_CTRL: begin
          dtr_q     <= reg_word(data_q);
          wr_data_q <= 1'b1;
          state_q   <= WR_DATA;
        end
        WR_DATA: begin
          cnt_q   <= '0;
          state_q <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          // A late IRQ coinciding with the last count still counts as success.
          if (bus.i_irq) begin
            rd_stat_q <= 1'b1;
            state_q   <= READ_STAT;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            rd_stat_q <= 1'b1;
            state_q   <= READ_STAT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        READ_STAT: begin
          done_q     <= grant_q;
          rx_q       <= bus.i_rx_data;
          err_coll_q <= bus.i_status_reg[STAT_COLL];
          err_tmo_q  <= timeout_q;
          state_q    <= DONE;
        end
        DONE: begin
          last_q     <= idx_q;
          grant_q    <= '0;
          rx_q       <= '0;
          err_coll_q <= 1'b0;
          err_tmo_q  <= 1'b0;
          timeout_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_grant             = grant_q;
  assign bus.o_done              = done_q;
  assign bus.o_rx_data           = rx_q;
  assign bus.o_err_collision     = err_coll_q;
  assign bus.o_err_timeout       = err_tmo_q;
  assign bus.o_data_to_registers = dtr_q;
  assign bus.o_wr_controll_reg   = wr_ctrl_q;
  assign bus.o_wr_data_reg       = wr_data_q;
  assign bus.o_read_status_reg   = rd_stat_q;

  assign unused_status = ^{bus.i_status_reg[31:STAT_COLL+1], bus.i_status_reg[STAT_COLL-1:0]};

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: a transaction-timeline model predicts every
// output each cycle; directed sequences add hand-computed literal checks.
module tb_spi_request_arbiter;
  import spi_ctrl_pkg::*;

  localparam int N = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic RST_N;
  always #5 clk = ~clk;

  spi_request_arbiter_if #(.NUM_REQ(N)) bus();

  spi_request_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: one active transaction described by its grant edge and IRQ/timeout edge.
  bit          mActive = 0;
  int          mWin = 0, mStart = 0, mEnd = -1, mLast = N - 1, mBlock = 0;
  bit          mTmo = 0, mColl = 0;
  logic [7:0]  mData = 0, mRx = 0;
  logic [31:0] mDtr = 0;

  logic [N-1:0] eGrant, eDone;
  logic         eWrc, eWrd, eRd, eColl, eTmo;
  logic [7:0]   eRx;
  logic [31:0]  eDtr;
  logic [N-1:0] one = 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelStep();
    if (RST_N !== 1'b1) begin
      mActive = 0; mLast = N - 1; mDtr = '0; mBlock = 0; mEnd = -1;
    end else if (!mActive) begin
      if (cyc >= mBlock && bus.i_req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (bus.i_req[(mLast + k) % N]) begin
            mWin = (mLast + k) % N;
            break;
          end
        end
        mActive = 1; mStart = cyc; mEnd = -1; mTmo = 0; mLast = mWin;
        mDtr  = {24'h0, bus.i_req_ctrl[8*mWin +: 8]};
        mData = bus.i_req_data[8*mWin +: 8];
      end
    end else begin
      if (cyc == mStart + 1) mDtr = {24'h0, mData};
      if (mEnd < 0 && cyc >= mStart + 3) begin
        if (bus.i_irq) mEnd = cyc;
        else if (cyc - (mStart + 3) == T - 1) begin mEnd = cyc; mTmo = 1; end
      end
      if (mEnd >= 0 && cyc == mEnd + 1) begin
        mRx = bus.i_rx_data; mColl = bus.i_status_reg[6];
      end
      if (mEnd >= 0 && cyc == mEnd + 2) begin
        mActive = 0; mBlock = cyc + 1;
      end
    end
    eGrant = mActive ? (one << mWin) : '0;
    eWrc   = mActive && cyc == mStart;
    eWrd   = mActive && cyc == mStart + 1;
    eRd    = mActive && mEnd >= 0 && cyc == mEnd;
    eDone  = (mActive && mEnd >= 0 && cyc == mEnd + 1) ? (one << mWin) : '0;
    eRx    = mRx; eColl = mColl; eTmo = mTmo;
    eDtr   = mDtr;
  endtask

  task automatic checkOutput();
    cmp("grant", 32'(bus.o_grant), 32'(eGrant));
    cmp("done", 32'(bus.o_done), 32'(eDone));
    cmp("wr_ctrl", 32'(bus.o_wr_controll_reg), 32'(eWrc));
    cmp("wr_data", 32'(bus.o_wr_data_reg), 32'(eWrd));
    cmp("rd_stat", 32'(bus.o_read_status_reg), 32'(eRd));
    cmp("data_to_regs", bus.o_data_to_registers, eDtr);
    if (eDone != '0) begin
      cmp("rx_data", 32'(bus.o_rx_data), 32'(eRx));
      cmp("err_coll", 32'(bus.o_err_collision), 32'(eColl));
      cmp("err_tmo", 32'(bus.o_err_timeout), 32'(eTmo));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    modelStep();
    checkOutput();
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < N; k++) begin
      if (eDone[k]) bus.i_req[k] = 1'b0;
      else if (!bus.i_req[k] && $urandom_range(0, 3) == 0) bus.i_req[k] = 1'b1;
    end
    bus.i_req_ctrl   = $urandom;
    bus.i_req_data   = $urandom;
    bus.i_irq        = ($urandom_range(0, 9) == 0);
    bus.i_status_reg = $urandom;
    bus.i_rx_data    = 8'($urandom);
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, " grant"}, 32'(bus.o_grant), 0);
    cmp({tag, " done"}, 32'(bus.o_done), 0);
    cmp({tag, " rx"}, 32'(bus.o_rx_data), 0);
    cmp({tag, " coll"}, 32'(bus.o_err_collision), 0);
    cmp({tag, " tmo"}, 32'(bus.o_err_timeout), 0);
    cmp({tag, " dtr"}, bus.o_data_to_registers, 0);
    cmp({tag, " wrc"}, 32'(bus.o_wr_controll_reg), 0);
    cmp({tag, " wrd"}, 32'(bus.o_wr_data_reg), 0);
    cmp({tag, " rd"}, 32'(bus.o_read_status_reg), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int order[$];
    int expOrder[5] = '{0, 1, 2, 3, 0};
    bit got;

    RST_N = 1'b0;
    bus.i_req = '0; bus.i_req_ctrl = '0; bus.i_req_data = '0;
    bus.i_irq = 1'b0; bus.i_status_reg = '0; bus.i_rx_data = '0;
    tick(); tick();
    checkAllZero("reset");
    RST_N = 1'b1;

    // Single requester 0, IRQ about ten cycles into WAIT_IRQ.
    bus.i_req = 4'b0001;
    bus.i_req_ctrl[7:0] = 8'h80; bus.i_req_data[7:0] = 8'hA5;
    bus.i_rx_data = 8'h3C; bus.i_status_reg = 32'h80;
    tick();
    cmp("d1 grant", 32'(bus.o_grant), 32'h1);
    cmp("d1 wrc", 32'(bus.o_wr_controll_reg), 1);
    cmp("d1 ctrl word", bus.o_data_to_registers, 32'h80);
    bus.i_req_data[7:0] = 8'h5A;
    tick();
    cmp("d1 wrd", 32'(bus.o_wr_data_reg), 1);
    cmp("d1 data word", bus.o_data_to_registers, 32'hA5);
    repeat (10) tick();
    bus.i_irq = 1'b1;
    tick();
    cmp("d1 rd", 32'(bus.o_read_status_reg), 1);
    bus.i_irq = 1'b0;
    tick();
    cmp("d1 done", 32'(bus.o_done), 32'h1);
    cmp("d1 rx", 32'(bus.o_rx_data), 32'h3C);
    cmp("d1 coll", 32'(bus.o_err_collision), 0);
    cmp("d1 tmo", 32'(bus.o_err_timeout), 0);
    bus.i_req = '0;
    tick();
    cmp("d1 grant clear", 32'(bus.o_grant), 0);
    tick();

    // Collision flag from status 0xC0, requester 1.
    bus.i_req = 4'b0010; bus.i_status_reg = 32'hC0; bus.i_rx_data = 8'h11; bus.i_irq = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) cmp("d2 grant", 32'(bus.o_grant), 32'h2);
      if (i == 4) cmp("d2 rd", 32'(bus.o_read_status_reg), 1);
      if (i == 5) begin
        cmp("d2 done", 32'(bus.o_done), 32'h2);
        cmp("d2 coll", 32'(bus.o_err_collision), 1);
        cmp("d2 rx", 32'(bus.o_rx_data), 32'h11);
      end
    end
    bus.i_req = '0; bus.i_irq = 1'b0; bus.i_status_reg = '0;
    tick(); tick();

    // Timeout on requester 2: IRQ never rises.
    bus.i_req = 4'b0100;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1)  cmp("d3 grant", 32'(bus.o_grant), 32'h4);
      if (i == 18) cmp("d3 rd early", 32'(bus.o_read_status_reg), 0);
      if (i == 19) cmp("d3 rd", 32'(bus.o_read_status_reg), 1);
      if (i == 20) begin
        cmp("d3 done", 32'(bus.o_done), 32'h4);
        cmp("d3 tmo", 32'(bus.o_err_timeout), 1);
      end
    end
    bus.i_req = '0;
    tick(); tick();

    // Round robin from reset with all requesters held high.
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    bus.i_req = 4'b1111; bus.i_irq = 1'b1;
    for (int i = 0; i < 200 && order.size() < 5; i++) begin
      tick();
      for (int k = 0; k < N; k++) if (bus.o_done[k]) order.push_back(k);
    end
    bus.i_req = '0; bus.i_irq = 1'b0;
    if (order.size() < 5) begin
      miscompares++;
      $display("[TB] FAIL rr budget: got %0d completions expected 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) cmp($sformatf("rr order[%0d]", i), order[i], expOrder[i]);
    end
    tick(); tick(); tick();

    // Reset during WAIT_IRQ, then requester 0 must win first.
    bus.i_req = 4'b0010;
    repeat (5) tick();
    RST_N = 1'b0;
    #1;
    checkAllZero("async reset");
    tick(); tick();
    RST_N = 1'b1;
    bus.i_req = 4'b0011;
    tick();
    cmp("post-reset grant", 32'(bus.o_grant), 32'h1);
    bus.i_irq = 1'b1; bus.i_status_reg = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.o_done != '0) begin
        got = 1;
        cmp("post-reset done", 32'(bus.o_done), 32'h1);
      end
    end
    if (!got) begin
      miscompares++;
      $display("[TB] FAIL post-reset budget: got no done expected done[0]");
    end
    bus.i_req = '0; bus.i_irq = 1'b0;
    tick(); tick();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      if (i == 1500) RST_N = 1'b0;
      if (i == 1503) RST_N = 1'b1;
      tick();
    end
    bus.i_req = '0; bus.i_irq = 1'b0;
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
